// File: rtl/mdu_ctrl.sv
// Execute-stage sequencer for the shared RV64 multiply/divide unit.
// Optional macro MDU_CTRL_BYPASS_EN resolves trivial div/rem/mul cases at accept time.
module mdu_ctrl #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             mdu_mul,
    output logic             mdu_mulh,
    output logic             mdu_mulhu,
    output logic             mdu_mulhsu,
    output logic             mdu_div,
    output logic             mdu_divu,
    output logic             mdu_rem,
    output logic             mdu_remu,
    output logic [XLEN-1:0]  mdu_src1,
    output logic [XLEN-1:0]  mdu_src2,
    output logic             mdu_flush,
    input  logic [XLEN-1:0]  mdu_result,
    input  logic             mdu_ready
);

    localparam int unsigned NUM_OPS = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [XLEN-1:0]    src1_q, src1_d;
    logic [XLEN-1:0]    src2_q, src2_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [NUM_OPS-1:0] op_q, op_d;
    logic               out_valid_q, out_valid_d;

    logic               accept_c;
    logic               byp_hit_c;
    logic [XLEN-1:0]    byp_val_c;

    assign in_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept_c = in_valid && in_ready;

`ifdef MDU_CTRL_BYPASS_EN
    // Results known from the operands alone: divide by zero, signed overflow, multiply by zero.
    logic [XLEN-1:0] min_signed_c;
    logic            src1_zero_c, src2_zero_c, ovf_c;

    always_comb begin
        min_signed_c = {1'b1, {(XLEN-1){1'b0}}};
        src1_zero_c  = (in_src1 == '0);
        src2_zero_c  = (in_src2 == '0);
        ovf_c        = (in_src1 == min_signed_c) && (in_src2 == '1);
        byp_hit_c    = 1'b0;
        byp_val_c    = '0;
        case (in_funct3)
            3'd4: begin
                if (src2_zero_c) begin
                    byp_hit_c = 1'b1;
                    byp_val_c = '1;
                end else if (ovf_c) begin
                    byp_hit_c = 1'b1;
                    byp_val_c = in_src1;
                end
            end
            3'd5: begin
                if (src2_zero_c) begin
                    byp_hit_c = 1'b1;
                    byp_val_c = '1;
                end
            end
            3'd6: begin
                if (src2_zero_c) begin
                    byp_hit_c = 1'b1;
                    byp_val_c = in_src1;
                end else if (ovf_c) begin
                    byp_hit_c = 1'b1;
                    byp_val_c = '0;
                end
            end
            3'd7: begin
                if (src2_zero_c) begin
                    byp_hit_c = 1'b1;
                    byp_val_c = in_src1;
                end
            end
            default: begin
                if (src1_zero_c || src2_zero_c) begin
                    byp_hit_c = 1'b1;
                    byp_val_c = '0;
                end
            end
        endcase
    end
`else
    assign byp_hit_c = 1'b0;
    assign byp_val_c = '0;
`endif

    // Next-state, operand latch and result capture; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        tag_d     = tag_q;
        res_d     = res_q;
        res_tag_d = res_tag_q;

        case (state_q)
            S_IDLE: ;
            S_BUSY: begin
                if (mdu_ready) begin
                    state_d   = S_DONE;
                    res_d     = mdu_result;
                    res_tag_d = tag_q;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept_c) begin
            funct3_d = in_funct3;
            src1_d   = in_src1;
            src2_d   = in_src2;
            tag_d    = in_tag;
            if (byp_hit_c) begin
                state_d   = S_DONE;
                res_d     = byp_val_c;
                res_tag_d = in_tag;
            end else begin
                state_d = S_BUSY;
            end
        end

        if (flush) state_d = S_IDLE;

        out_valid_d = (state_d == S_DONE);
        op_d        = (state_d == S_BUSY) ? (8'b1 << funct3_d) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            funct3_q    <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            tag_q       <= '0;
            res_q       <= '0;
            res_tag_q   <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            tag_q       <= tag_d;
            res_q       <= res_d;
            res_tag_q   <= res_tag_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_tag    = res_tag_q;
    assign mdu_src1   = src1_q;
    assign mdu_src2   = src2_q;
    assign mdu_flush  = flush;

    // Line index equals funct3.
    assign mdu_mul    = op_q[0];
    assign mdu_mulh   = op_q[1];
    assign mdu_mulhsu = op_q[2];
    assign mdu_mulhu  = op_q[3];
    assign mdu_div    = op_q[4];
    assign mdu_divu   = op_q[5];
    assign mdu_rem    = op_q[6];
    assign mdu_remu   = op_q[7];

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a behavioural multiply/divide unit of programmable latency.
module tb_mdu_ctrl;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [2:0]  in_funct3;
    logic [63:0] in_src1, in_src2, out_result, mdu_src1, mdu_src2, mdu_result;
    logic [4:0]  in_tag, out_tag;
    logic        mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu;
    logic        mdu_div, mdu_divu, mdu_rem, mdu_remu;
    logic        mdu_flush, mdu_ready;
    logic [7:0]  ops;

    int checks = 0;
    int errors = 0;
    int unit_lat = 1;
    int cnt = 0;

`ifdef MDU_CTRL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clock = ~clock;

    mdu_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .mdu_mul(mdu_mul), .mdu_mulh(mdu_mulh), .mdu_mulhu(mdu_mulhu), .mdu_mulhsu(mdu_mulhsu),
        .mdu_div(mdu_div), .mdu_divu(mdu_divu), .mdu_rem(mdu_rem), .mdu_remu(mdu_remu),
        .mdu_src1(mdu_src1), .mdu_src2(mdu_src2), .mdu_flush(mdu_flush),
        .mdu_result(mdu_result), .mdu_ready(mdu_ready)
    );

    assign ops = {mdu_remu, mdu_rem, mdu_divu, mdu_div, mdu_mulhu, mdu_mulhsu, mdu_mulh, mdu_mul};

    // Unit stub: completes in the unit_lat-th cycle an op line is held; idle reports ready.
    always_ff @(posedge clock) cnt <= (ops != 8'd0) ? cnt + 1 : 0;
    assign mdu_ready = (ops == 8'd0) || (cnt == unit_lat - 1);

    localparam logic [63:0] MIN_S = 64'h8000_0000_0000_0000;
    logic [127:0] p_uu, p_ss, p_su;
    always_comb begin
        p_uu = {64'd0, mdu_src1} * {64'd0, mdu_src2};
        p_ss = {{64{mdu_src1[63]}}, mdu_src1} * {{64{mdu_src2[63]}}, mdu_src2};
        p_su = {{64{mdu_src1[63]}}, mdu_src1} * {64'd0, mdu_src2};
        mdu_result = 64'd0;
        if (mdu_mul)    mdu_result = p_uu[63:0];
        if (mdu_mulh)   mdu_result = p_ss[127:64];
        if (mdu_mulhsu) mdu_result = p_su[127:64];
        if (mdu_mulhu)  mdu_result = p_uu[127:64];
        if (mdu_divu)   mdu_result = (mdu_src2 == 64'd0) ? '1 : mdu_src1 / mdu_src2;
        if (mdu_remu)   mdu_result = (mdu_src2 == 64'd0) ? mdu_src1 : mdu_src1 % mdu_src2;
        if (mdu_div) begin
            if (mdu_src2 == 64'd0)                        mdu_result = '1;
            else if (mdu_src1 == MIN_S && mdu_src2 == '1) mdu_result = mdu_src1;
            else mdu_result = 64'($signed(mdu_src1) / $signed(mdu_src2));
        end
        if (mdu_rem) begin
            if (mdu_src2 == 64'd0)                        mdu_result = mdu_src1;
            else if (mdu_src1 == MIN_S && mdu_src2 == '1) mdu_result = 64'd0;
            else mdu_result = 64'($signed(mdu_src1) % $signed(mdu_src2));
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [4:0]  tag;
        int          lat;
        bit          triv;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [63:0] s1, input logic [63:0] s2,
                            input logic [4:0] tag);
        in_funct3 = f3;
        in_src1   = s1;
        in_src2   = s2;
        in_tag    = tag;
        in_valid  = 1'b1;
    endtask

    // Issues one op from IDLE with out_ready high; checks latency, op-line activity and result.
    task automatic run_vec(input vec_t v);
        int  c, opc, exp_c, exp_opc;
        bit  bad;
        unit_lat = v.lat;
        @(negedge clock);
        drive_op(v.f3, v.s1, v.s2, v.tag);
        out_ready = 1'b1;
        #1 chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        opc = 0;
        bad = 1'b0;
        for (c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clock);
            if (ops != 8'd0) begin
                opc++;
                if (ops != (8'b1 << v.f3)) bad = 1'b1;
                if (mdu_src1 !== v.s1 || mdu_src2 !== v.s2) bad = 1'b1;
            end
            if (out_valid) break;
        end
        exp_c   = (BYP && v.triv) ? 1 : v.lat + 1;
        exp_opc = (BYP && v.triv) ? 0 : v.lat;
        chk("latency", 64'(c), 64'(exp_c));
        chk("op_cycles", 64'(opc), 64'(exp_opc));
        chk("op_onehot_src_stable", 64'(bad), 64'd0);
        chk("result", out_result, v.exp);
        chk("tag", 64'(out_tag), 64'(v.tag));
        @(negedge clock);
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("ops_release", 64'(ops), 64'd0);
    endtask

    task automatic wait_valid(output int c);
        for (c = 1; c <= 40; c++) begin
            if (out_valid) break;
            @(negedge clock);
        end
    endtask

    task automatic check_reset_values(input string tagname);
        chk({tagname, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tagname, "_ops"}, 64'(ops), 64'd0);
        chk({tagname, "_out_result"}, out_result, 64'd0);
        chk({tagname, "_out_tag"}, 64'(out_tag), 64'd0);
        chk({tagname, "_src1"}, mdu_src1, 64'd0);
        chk({tagname, "_src2"}, mdu_src2, 64'd0);
        chk({tagname, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int  c;
        bit  seen;

        vecs[0]  = '{3'd0, 64'd7, 64'd6, 5'd5, 3, 1'b0, 64'd42};
        vecs[1]  = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd1, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{3'd3, 64'h8000_0000_0000_0000, 64'd4, 5'd3, 2, 1'b0, 64'd2};
        vecs[4]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd4, 4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[5]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd6, 4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[6]  = '{3'd5, 64'd100, 64'd7, 5'd7, 5, 1'b0, 64'd14};
        vecs[7]  = '{3'd7, 64'd100, 64'd7, 5'd8, 1, 1'b0, 64'd2};
        vecs[8]  = '{3'd4, 64'd5, 64'd0, 5'd11, 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 2, 1'b1, 64'd0};
        vecs[10] = '{3'd0, 64'd0, 64'd123, 5'd13, 2, 1'b1, 64'd0};
        vecs[11] = '{3'd7, 64'd9, 64'd0, 5'd14, 3, 1'b1, 64'd9};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_funct3 = 3'd0; in_src1 = 64'd0; in_src2 = 64'd0; in_tag = 5'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1 check_reset_values("reset");

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Backpressure on the result, then a back-to-back accept from DONE.
        unit_lat = 3;
        @(negedge clock);
        drive_op(3'd5, 64'd100, 64'd7, 5'd9);
        out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        wait_valid(c);
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_result", out_result, 64'd14);
            chk("bp_hold_tag", 64'(out_tag), 64'd9);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        drive_op(3'd6, 64'd100, 64'd7, 5'd10);
        #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        chk("b2b_rem_line", 64'(ops), 64'h40);
        chk("b2b_valid_low", 64'(out_valid), 64'd0);
        wait_valid(c);
        chk("b2b_rem_result", out_result, 64'd2);
        chk("b2b_rem_tag", 64'(out_tag), 64'd10);
        @(negedge clock);

        // Flush during the second BUSY cycle, with a new op offered in the flush cycle.
        unit_lat = 10;
        drive_op(3'd4, 64'd100, 64'd7, 5'd3);
        @(negedge clock);
        in_valid = 1'b0;
        chk("fl_div_line", 64'(ops), 64'h10);
        @(negedge clock);
        flush = 1'b1;
        drive_op(3'd0, 64'd7, 64'd6, 5'd4);
        #1 chk("fl_mdu_flush", 64'(mdu_flush), 64'd1);
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        @(negedge clock);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_ops_drop", 64'(ops), 64'd0);
        #1 chk("fl_idle_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        chk("fl_no_valid", 64'(seen), 64'd0);
        run_vec(vecs[3]);

        // Flush coinciding with unit completion drops the result.
        unit_lat = 2;
        drive_op(3'd0, 64'd7, 64'd6, 5'd6);
        @(negedge clock);
        in_valid = 1'b0;
        chk("flr_mul_line", 64'(ops), 64'h01);
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flr_valid", 64'(out_valid), 64'd0);
        chk("flr_ops", 64'(ops), 64'd0);
        #1 chk("flr_idle", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        chk("flr_no_valid", 64'(seen), 64'd0);

        // Reset in the middle of BUSY.
        unit_lat = 10;
        drive_op(3'd0, 64'd7, 64'd6, 5'd7);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1 chk("rst_no_mdu_flush", 64'(mdu_flush), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 check_reset_values("midrst");

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Execute-stage sequencer for the shared multiply/divide unit (RV64 M-extension).
- Accepts one M-op per valid/ready handshake and latches its operands and tag.
- Drives the unit's one-hot op lines until it reports completion, then buffers the result for a valid/ready writeback consumer.
- Handles pipeline flush and guarantees the op lines drop for at least one cycle between operations.

Parameters:
- XLEN, 64, operand/result width
- TAG_W, 5, width of the opaque destination tag carried alongside the op

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  cancel any in-flight or buffered op
- in_valid  in  1  upstream op valid
- in_ready  out  1  controller can accept an op this cycle
- in_funct3  in  3  RISC-V M funct3: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
- in_src1  in  XLEN  rs1 value
- in_src2  in  XLEN  rs2 value
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result buffered
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of result
- mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu, mdu_div, mdu_divu, mdu_rem, mdu_remu  out  1 each  one-hot op lines to unit
- mdu_src1, mdu_src2  out  XLEN  latched operands
- mdu_flush  out  1  flush to unit
- mdu_result  in  XLEN  unit result
- mdu_ready  in  1  unit completion (high when idle or result valid)

Behaviour:
- Reset (synchronous, active-high): state IDLE; out_valid=0; all op lines=0; out_result=0; out_tag=0; mdu_src1/2=0.
- States:
  - IDLE → BUSY on accept.
  - BUSY → DONE when mdu_ready=1; mdu_result and tag are captured at that edge.
  - DONE → IDLE on out_valid & out_ready with no new accept; DONE → BUSY on out_ready with a simultaneous accept.
- in_ready = !flush & (IDLE | (DONE & out_ready)).
- Accept = in_valid & in_ready. Latch funct3, src1, src2, tag.
- Op lines: exactly one asserted, decoded from the latched funct3, and only while state==BUSY. All zero in IDLE and DONE, so every op sees at least one release cycle.
- mdu_src1/2 are held stable for the whole BUSY period.
- Latency: accept at edge N; op lines high in cycle N+1; with unit completion at cycle N+k, out_valid is high from cycle N+k+1. Minimum accept-to-out_valid is 2 cycles.
- out_valid holds while out_ready=0; out_result and out_tag stay stable.
- Flush has highest priority:
  - mdu_flush = flush, combinational pass-through.
  - Next state IDLE; out_valid cleared next edge; op lines drop next cycle.
  - in_valid in the flush cycle is ignored (in_ready=0).
  - Flush in the same cycle as mdu_ready discards the result.
- Reset mid-operation: same as flush, but mdu_flush is not asserted; the unit has its own reset.
- mdu_ready sampled in IDLE/DONE is ignored.

Optional Feature:
- MDU_CTRL_BYPASS_EN
- With the macro defined, the controller resolves trivial cases at accept time, without engaging the unit. The result goes straight into the DONE buffer, with out_valid high the cycle after accept. No op lines are asserted and no BUSY cycle occurs. Trivial cases:
  - div/divu with src2==0: all-ones.
  - rem/remu with src2==0: src1.
  - div with src1==min-signed and src2==-1: src1.
  - rem with src1==min-signed and src2==-1: 0.
  - Any multiply with src1==0 or src2==0: 0.
- With the macro undefined, every op goes through the unit. Port list is identical either way.

Test Plan:
- mul: src1=7, src2=6; unit ready 3 cycles after op lines rise → mdu_mul high exactly 3 cycles; out_result=42 with tag preserved; all op lines 0 the cycle after.
- divu: src1=100, src2=7, with out_ready=0 for 5 cycles after out_valid → out_result=14 held stable; in_ready=0 until out_ready=1; then back-to-back accept of rem (src1=100, src2=7) gives out_result=2.
- Flush in the 2nd BUSY cycle of div → mdu_flush=1 that cycle; op lines 0 next cycle; out_valid never asserts; next mulhu(2^63, 4) returns 2.
- Flush coincident with mdu_ready → result dropped, out_valid stays 0, state IDLE.
- Reset asserted mid-BUSY → next cycle all outputs at reset values, in_ready=1.
- With MDU_CTRL_BYPASS_EN: div(src1=5, src2=0) → out_valid the cycle after accept, out_result=0xFFFF_FFFF_FFFF_FFFF, no op line ever high. Same stimulus without the macro → mdu_div asserted, result taken from the unit.
